uart_rx_fifo_ctrl: RTL and testbench

//  Parametrised UART receiver: baud-tick generator, oversampled RX FSM and a show-ahead receive FIFO.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 66 ++++++
 rtl/uart_rx_fifo_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the UART receive path: RX state
//                encodings and parity mode selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // RX state machine encodings
    localparam int         c_ST_W      = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Parity mode selectors for the PARITY parameter
    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_EVEN = 1;
    localparam int c_PAR_ODD  = 2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Synchronous show-ahead FIFO for received UART words.
//                The head entry is presented combinationally while not empty.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_wr_en/i_wr_data - push request and word
//                i_rd_en         - pop head (ignored when empty)
//                o_rd_data       - head word (zero while empty)
//                o_empty/o_full  - occupancy flags
//                o_drop          - 1-clk pulse: push lost because FIFO full
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);

    localparam int c_DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A simultaneous pop frees the slot a full-FIFO push lands in; the head
    // is read before the edge, so overwriting that slot is safe.
    assign w_pop  = i_rd_en && !o_empty;
    assign w_push = i_wr_en && (!o_full || w_pop);
    assign o_drop = i_wr_en && o_full && !w_pop;

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_ctrl
//  Description : Oversampling UART receiver with baud-tick divider, 2-FF rx
//                synchroniser, start/data/parity/stop FSM and a show-ahead
//                receive FIFO carrying per-word parity/framing flags.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                rx              - asynchronous serial line, idle high
//                rd_en           - pop head entry (ignored when empty)
//                clr_overrun     - clears sticky overrun
//                rd_data/rd_perr/rd_ferr - head entry payload and flags
//                empty/full      - FIFO occupancy
//                overrun         - sticky: frame dropped on full FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 163,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic                 clr_overrun,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 rd_ferr,
    output logic                 empty,
    output logic                 full,
    output logic                 overrun
);

    localparam int c_DIV_W  = (BAUD_DIV > 0) ? $clog2(BAUD_DIV + 1) : 1;
    localparam int c_TICK_W = $clog2(OVS);
    localparam int c_BIT_W  = $clog2(DATA_BITS);
    localparam int c_WORD_W = DATA_BITS + 2;

    // ---------------- rx synchroniser (resets to idle level) ----------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ---------------- free-running baud tick divider ----------------
    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;

    assign w_tick = (r_div == c_DIV_W'(BAUD_DIV));

    always_ff @(posedge clk) begin
        if (reset)       r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // ---------------- receive FSM ----------------
    logic [c_ST_W-1:0]    r_state;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_done;
    logic                 w_bit_end;
    logic                 w_exp_par;

    // One full bit period elapsed since the previous sample point
    assign w_bit_end = (r_tick_cnt == c_TICK_W'(OVS - 1));
    assign w_exp_par = (PARITY == c_PAR_ODD) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= c_ST_START;
                        r_tick_cnt <= '0;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        // Half-bit check filters glitches shorter than half a bit
                        if (r_tick_cnt == c_TICK_W'(OVS / 2 - 1)) begin
                            r_tick_cnt <= '0;
                            if (!r_rx_s) begin
                                r_state   <= c_ST_DATA;
                                r_bit_cnt <= '0;
                                r_perr    <= 1'b0;
                                r_ferr    <= 1'b0;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        if (w_bit_end) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == c_BIT_W'(DATA_BITS - 1)) begin
                                r_stop_cnt <= 1'b0;
                                r_state    <= (PARITY != c_PAR_NONE) ? c_ST_PARITY : c_ST_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_tick) begin
                        if (w_bit_end) begin
                            r_tick_cnt <= '0;
                            r_perr     <= (r_rx_s != w_exp_par);
                            r_state    <= c_ST_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                c_ST_STOP: begin
                    if (w_tick) begin
                        if (w_bit_end) begin
                            r_tick_cnt <= '0;
                            if (!r_rx_s) r_ferr <= 1'b1;
                            if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                                r_done  <= 1'b1;
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_stop_cnt <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    // Flags travel with the payload, so framing/parity errors are still pushed.
    logic [c_WORD_W-1:0] w_head;
    logic                w_drop;

    uart_rx_fifo #(
        .WIDTH (c_WORD_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (r_done),
        .i_wr_data ({r_ferr, r_perr, r_shift}),
        .i_rd_en   (rd_en),
        .o_rd_data (w_head),
        .o_empty   (empty),
        .o_full    (full),
        .o_drop    (w_drop)
    );

    assign rd_data = w_head[DATA_BITS-1:0];
    assign rd_perr = w_head[DATA_BITS];
    assign rd_ferr = w_head[DATA_BITS+1];

    // Sticky overrun; a new drop in the same clk beats the clear
    always_ff @(posedge clk) begin
        if (reset)            overrun <= 1'b0;
        else if (w_drop)      overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

endmodule : uart_rx_fifo_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_fifo_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_fifo_ctrl
//  Description : Self-checking bench for uart_rx_fifo_ctrl. Instance 0 is 8N1,
//                instance 1 is 8E1; both run at 64 clk per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_ctrl;

    localparam int c_BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx0, rx1, rd_en0, rd_en1, clr0, clr1;
    logic [7:0] rd_data0, rd_data1;
    logic       perr0, ferr0, empty0, full0, overrun0;
    logic       perr1, ferr1, empty1, full1, overrun1;

    int n_pass  = 0;
    int n_total = 0;

    logic [9:0] sb0[$];
    logic [9:0] sb1[$];

    always #5 clk = ~clk;

    uart_rx_fifo_ctrl #(
        .BAUD_DIV(3), .OVS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)
    ) u_dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .rd_en(rd_en0), .clr_overrun(clr0),
        .rd_data(rd_data0), .rd_perr(perr0), .rd_ferr(ferr0),
        .empty(empty0), .full(full0), .overrun(overrun0)
    );

    uart_rx_fifo_ctrl #(
        .BAUD_DIV(3), .OVS(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(2)
    ) u_dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .rd_en(rd_en1), .clr_overrun(clr1),
        .rd_data(rd_data1), .rd_perr(perr1), .rd_ferr(ferr1),
        .empty(empty1), .full(full1), .overrun(overrun1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [9:0] head(input int which);
        return (which == 0) ? {ferr0, perr0, rd_data0} : {ferr1, perr1, rd_data1};
    endfunction

    function automatic logic is_empty(input int which);
        return (which == 0) ? empty0 : empty1;
    endfunction

    // Hold the line at value v for n clocks (called at a negedge)
    task automatic drive_bit(input int which, input logic v, input int n);
        if (which == 0) rx0 = v; else rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input logic has_par,
                              input logic par_bit, input logic stop_bit, input int stop_clk,
                              input logic expect_push);
        logic [9:0] exp;
        exp[7:0] = data;
        exp[8]   = has_par && (par_bit != (^data));
        exp[9]   = !stop_bit;
        if (expect_push) begin
            if (which == 0) sb0.push_back(exp); else sb1.push_back(exp);
        end
        drive_bit(which, 1'b0, c_BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], c_BIT_CLK);
        if (has_par) drive_bit(which, par_bit, c_BIT_CLK);
        drive_bit(which, stop_bit, stop_clk);
        drive_bit(which, 1'b1, 24);
    endtask

    task automatic wait_not_empty(input int which, input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!is_empty(which)) break;
            @(negedge clk);
        end
        check(tag, is_empty(which), 1'b0);
    endtask

    // Compare the head against the scoreboard, then pop it
    task automatic pop_check(input int which, input string tag);
        logic [9:0] exp;
        logic [9:0] act;
        if (((which == 0) ? sb0.size() : sb1.size()) == 0) begin
            check({tag, "_sb_empty"}, is_empty(which), 1'b1);
            return;
        end
        exp = (which == 0) ? sb0.pop_front() : sb1.pop_front();
        act = head(which);
        check({tag, "_data"}, act[7:0], exp[7:0]);
        check({tag, "_perr"}, act[8], exp[8]);
        check({tag, "_ferr"}, act[9], exp[9]);
        if (which == 0) rd_en0 = 1'b1; else rd_en1 = 1'b1;
        @(negedge clk);
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1;
        rd_en0 = 1'b0; rd_en1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_empty0",   empty0,   1'b1);
        check("rst_full0",    full0,    1'b0);
        check("rst_overrun0", overrun0, 1'b0);
        check("rst_head0",    head(0),  10'h000);
        check("rst_empty1",   empty1,   1'b1);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 frame 0xA5, single pop, then a pop on empty must be harmless
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, c_BIT_CLK, 1'b1);
        wait_not_empty(0, "a5_visible", 50);
        pop_check(0, "a5");
        check("a5_empty_after_pop", empty0, 1'b1);
        rd_en0 = 1'b1; @(negedge clk); rd_en0 = 1'b0;
        check("empty_pop_noop", empty0, 1'b0 ^ 1'b1);

        // Even parity: 0x07 needs parity bit 1
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, c_BIT_CLK, 1'b1);
        wait_not_empty(1, "par_bad_visible", 50);
        pop_check(1, "par_bad");
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, c_BIT_CLK, 1'b1);
        wait_not_empty(1, "par_ok_visible", 50);
        pop_check(1, "par_ok");

        // Framing error: stop bit low long enough to cover the sample point
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 48, 1'b1);
        drive_bit(0, 1'b1, 100);
        wait_not_empty(0, "ferr_visible", 50);
        pop_check(0, "ferr");
        check("ferr_no_extra", empty0, 1'b1);

        // Fill the FIFO, then overrun with 0x05
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, c_BIT_CLK, 1'b1);
        check("fill_full", full0, 1'b1);
        check("fill_no_overrun", overrun0, 1'b0);
        send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1, c_BIT_CLK, 1'b0);
        check("ovr_set", overrun0, 1'b1);
        check("ovr_full", full0, 1'b1);
        for (int i = 1; i <= 4; i++) pop_check(0, $sformatf("fifo%0d", i));
        check("drain_empty", empty0, 1'b1);
        check("drain_not_full", full0, 1'b0);
        check("ovr_sticky", overrun0, 1'b1);
        clr0 = 1'b1; @(negedge clk); clr0 = 1'b0;
        check("ovr_cleared", overrun0, 1'b0);

        // Short low glitch on the line
        drive_bit(0, 1'b0, 20);
        drive_bit(0, 1'b1, 200);
        check("glitch_empty", empty0, 1'b1);
        check("glitch_overrun", overrun0, 1'b0);

        // Leave 0x11 in the FIFO, then reset in the middle of 0x55's data bits
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, c_BIT_CLK, 1'b1);
        wait_not_empty(0, "pre_reset_visible", 50);
        drive_bit(0, 1'b0, c_BIT_CLK);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'(8'h55 >> i), c_BIT_CLK);
        drive_bit(0, 1'b0, 30);
        reset = 1'b1;
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_empty",   empty0,   1'b1);
        check("midrst_full",    full0,    1'b0);
        check("midrst_overrun", overrun0, 1'b0);
        check("midrst_head",    head(0),  10'h000);
        sb0.delete();
        reset = 1'b0;
        drive_bit(0, 1'b1, 200);
        check("post_rst_no_push", empty0, 1'b1);
        send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1, c_BIT_CLK, 1'b1);
        wait_not_empty(0, "post_rst_visible", 50);
        pop_check(0, "post_rst");
        check("post_rst_empty", empty0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_rx_fifo_ctrl
`default_nettype wire
